// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing one register-file write port (plus r7 overflow side-write).
// Optional build macro RF_SPLIT_OVER_EN: overflow side-writes become a second r7 beat.
module regfile_write_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid_i,
    output logic [NUM_REQ-1:0]         req_ready_o,
    input  logic [NUM_REQ*ADDR_W-1:0]  req_dest_i,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data_i,
    input  logic [NUM_REQ-1:0]         req_over_i,
    input  logic [NUM_REQ*DATA_W-1:0]  req_overdata_i,
    output logic                       writeFlag_o,
    output logic                       overFlag_o,
    output logic [ADDR_W-1:0]          destReg_o,
    output logic [DATA_W-1:0]          data_o,
    output logic [DATA_W-1:0]          over_o,
    output logic [$clog2(NUM_REQ)-1:0] grant_id_o,
    output logic                       busy_o
);
    localparam int GID_W = $clog2(NUM_REQ);
    localparam logic [ADDR_W-1:0] R7 = '1;

`ifdef RF_SPLIT_OVER_EN
    typedef enum logic {IDLE, OVER} state_t;
    logic [DATA_W-1:0] pend_q, pend_d;
`else
    typedef enum logic {IDLE} state_t;
`endif

    state_t             state_q, state_d;
    logic [GID_W-1:0]   ptr_q, ptr_d;
    logic               wr_q, wr_d;
    logic               ovf_q, ovf_d;
    logic [ADDR_W-1:0]  dest_q, dest_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic [DATA_W-1:0]  over_q, over_d;
    logic [GID_W-1:0]   gid_q, gid_d;

    logic               can_accept;
    logic               found;
    logic [GID_W-1:0]   gsel;
    logic [NUM_REQ-1:0] grant;
    logic               accept;
    logic [ADDR_W-1:0]  sel_dest;
    logic [DATA_W-1:0]  sel_data;
    logic [DATA_W-1:0]  sel_overdata;
    logic               sel_over;

    // Ready is gated by rst_n so nothing is offered while reset is asserted.
`ifdef RF_SPLIT_OVER_EN
    assign can_accept = rst_n && (state_q == IDLE);
    assign busy_o     = (state_q == OVER);
`else
    assign can_accept = rst_n;
    assign busy_o     = 1'b0;
`endif

    always_comb begin
        int idx;
        idx   = 0;
        found = 1'b0;
        gsel  = '0;
        grant = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr_q) + k) % NUM_REQ;
            if (!found && req_valid_i[idx]) begin
                found = 1'b1;
                gsel  = GID_W'(idx);
            end
        end
        if (found && can_accept) begin
            grant[gsel] = 1'b1;
        end
    end

    assign req_ready_o  = grant;
    assign accept       = |grant;
    assign sel_dest     = req_dest_i[int'(gsel)*ADDR_W +: ADDR_W];
    assign sel_data     = req_data_i[int'(gsel)*DATA_W +: DATA_W];
    assign sel_overdata = req_overdata_i[int'(gsel)*DATA_W +: DATA_W];
    assign sel_over     = req_over_i[gsel];

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        wr_d    = 1'b0;
        ovf_d   = 1'b0;
        dest_d  = dest_q;
        data_d  = data_q;
        over_d  = over_q;
        gid_d   = gid_q;
`ifdef RF_SPLIT_OVER_EN
        pend_d  = pend_q;
        if (state_q == OVER) begin
            wr_d    = 1'b1;
            dest_d  = R7;
            data_d  = pend_q;
            state_d = IDLE;
        end else
`endif
        if (accept) begin
            ptr_d  = (int'(gsel) == NUM_REQ - 1) ? '0 : gsel + 1'b1;
            wr_d   = 1'b1;
            gid_d  = gsel;
            dest_d = sel_dest;
            data_d = sel_data;
            if (sel_over) begin
                // Overflow aimed at r7 itself collapses to one beat; overflow data wins.
                if (sel_dest == R7) begin
                    data_d = sel_overdata;
                end else begin
`ifdef RF_SPLIT_OVER_EN
                    pend_d  = sel_overdata;
                    state_d = OVER;
`else
                    ovf_d   = 1'b1;
                    over_d  = sel_overdata;
`endif
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            wr_q    <= 1'b0;
            ovf_q   <= 1'b0;
            dest_q  <= '0;
            data_q  <= '0;
            over_q  <= '0;
            gid_q   <= '0;
`ifdef RF_SPLIT_OVER_EN
            pend_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            wr_q    <= wr_d;
            ovf_q   <= ovf_d;
            dest_q  <= dest_d;
            data_q  <= data_d;
            over_q  <= over_d;
            gid_q   <= gid_d;
`ifdef RF_SPLIT_OVER_EN
            pend_q  <= pend_d;
`endif
        end
    end

    assign writeFlag_o = wr_q;
    assign overFlag_o  = ovf_q;
    assign destReg_o   = dest_q;
    assign data_o      = data_q;
    assign over_o      = over_q;
    assign grant_id_o  = gid_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter; expectations hand-derived per step.
module tb_regfile_write_arbiter;
    localparam int NUM_REQ = 3;
    localparam int DATA_W  = 8;
    localparam int ADDR_W  = 3;
`ifdef RF_SPLIT_OVER_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic [NUM_REQ-1:0]        req_valid_i;
    logic [NUM_REQ-1:0]        req_ready_o;
    logic [NUM_REQ*ADDR_W-1:0] req_dest_i;
    logic [NUM_REQ*DATA_W-1:0] req_data_i;
    logic [NUM_REQ-1:0]        req_over_i;
    logic [NUM_REQ*DATA_W-1:0] req_overdata_i;
    logic                      writeFlag_o;
    logic                      overFlag_o;
    logic [ADDR_W-1:0]         destReg_o;
    logic [DATA_W-1:0]         data_o;
    logic [DATA_W-1:0]         over_o;
    logic [1:0]                grant_id_o;
    logic                      busy_o;

    int n_assert = 0;
    int n_fail   = 0;

    regfile_write_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_dest_i(req_dest_i), .req_data_i(req_data_i),
        .req_over_i(req_over_i), .req_overdata_i(req_overdata_i),
        .writeFlag_o(writeFlag_o), .overFlag_o(overFlag_o),
        .destReg_o(destReg_o), .data_o(data_o), .over_o(over_o),
        .grant_id_o(grant_id_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [ADDR_W-1:0] d,
                           input logic [DATA_W-1:0] dat, input logic ov,
                           input logic [DATA_W-1:0] ovd);
        req_valid_i[i]                  = v;
        req_dest_i[i*ADDR_W +: ADDR_W]  = d;
        req_data_i[i*DATA_W +: DATA_W]  = dat;
        req_over_i[i]                   = ov;
        req_overdata_i[i*DATA_W +: DATA_W] = ovd;
    endtask

    task automatic chk_wr(input string tag, input logic wf, input logic [ADDR_W-1:0] d,
                          input logic [DATA_W-1:0] dat, input logic [1:0] gid);
        chk({tag, ".wf"},   32'(writeFlag_o), 32'(wf));
        chk({tag, ".dest"}, 32'(destReg_o),   32'(d));
        chk({tag, ".data"}, 32'(data_o),      32'(dat));
        chk({tag, ".gid"},  32'(grant_id_o),  32'(gid));
        $display("step %s: wf=%0b ovf=%0b dest=%0d data=%02h gid=%0d busy=%0b",
                 tag, writeFlag_o, overFlag_o, destReg_o, data_o, grant_id_o, busy_o);
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid_i = '0; req_dest_i = '0; req_data_i = '0;
        req_over_i = '0; req_overdata_i = '0;
        // Test 1: reset with every requester valid.
        set_req(0, 1'b1, 3'd1, 8'hA0, 1'b0, 8'h00);
        set_req(1, 1'b1, 3'd2, 8'hA1, 1'b0, 8'h00);
        set_req(2, 1'b1, 3'd3, 8'hA2, 1'b0, 8'h00);
        tick(); tick();
        chk("rst.ready", 32'(req_ready_o), 32'h0);
        chk("rst.ovf",   32'(overFlag_o),  32'h0);
        chk("rst.over",  32'(over_o),      32'h0);
        chk("rst.busy",  32'(busy_o),      32'h0);
        chk_wr("rst", 1'b0, 3'd0, 8'h00, 2'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("rel.ready", 32'(req_ready_o), 32'b001);

        // Test 3: all held valid -> 0,1,2,0,1.
        tick(); chk_wr("rr0", 1'b1, 3'd1, 8'hA0, 2'd0);
        chk("rr0.ready", 32'(req_ready_o), 32'b010);
        tick(); chk_wr("rr1", 1'b1, 3'd2, 8'hA1, 2'd1);
        tick(); chk_wr("rr2", 1'b1, 3'd3, 8'hA2, 2'd2);
        tick(); chk_wr("rr3", 1'b1, 3'd1, 8'hA0, 2'd0);
        tick(); chk_wr("rr4", 1'b1, 3'd2, 8'hA1, 2'd1);
        req_valid_i = 3'b100;
        #1 chk("rr5.ready", 32'(req_ready_o), 32'b100);
        tick(); chk_wr("rr5", 1'b1, 3'd3, 8'hA2, 2'd2);
        req_valid_i = '0;
        #1 chk("idle.ready", 32'(req_ready_o), 32'b000);
        tick(); chk_wr("hold", 1'b0, 3'd3, 8'hA2, 2'd2);

        // Test 2: single write, ptr=0.
        set_req(0, 1'b1, 3'd3, 8'h5A, 1'b0, 8'h00);
        #1 chk("t2.ready", 32'(req_ready_o), 32'b001);
        tick(); chk_wr("t2.beat", 1'b1, 3'd3, 8'h5A, 2'd0);
        req_valid_i = '0;
        tick(); chk_wr("t2.after", 1'b0, 3'd3, 8'h5A, 2'd0);

        // Test 4: overflow side-write with dest!=7, ptr=1.
        set_req(1, 1'b1, 3'd2, 8'h10, 1'b1, 8'hFF);
        #1 chk("t4.ready", 32'(req_ready_o), 32'b010);
        tick(); chk_wr("t4.b1", 1'b1, 3'd2, 8'h10, 2'd1);
        req_valid_i = '0;
        if (!SPLIT) begin
            chk("t4.ovf",  32'(overFlag_o), 32'h1);
            chk("t4.over", 32'(over_o),     32'hFF);
            chk("t4.busy", 32'(busy_o),     32'h0);
            tick(); chk_wr("t4.after", 1'b0, 3'd2, 8'h10, 2'd1);
            chk("t4.ovf0", 32'(overFlag_o), 32'h0);
        end else begin
            set_req(0, 1'b1, 3'd5, 8'h33, 1'b0, 8'h00);
            #1;
            chk("t4.ovf",   32'(overFlag_o),  32'h0);
            chk("t4.busy",  32'(busy_o),      32'h1);
            chk("t4.rdy0",  32'(req_ready_o), 32'b000);
            tick(); chk_wr("t4.b2", 1'b1, 3'd7, 8'hFF, 2'd1);
            chk("t4.busy0", 32'(busy_o),      32'h0);
            chk("t4.ovf2",  32'(overFlag_o),  32'h0);
            chk("t4.rdy1",  32'(req_ready_o), 32'b001);
            tick(); chk_wr("t4.next", 1'b1, 3'd5, 8'h33, 2'd0);
            req_valid_i = '0;
            tick(); chk_wr("t4.after", 1'b0, 3'd5, 8'h33, 2'd0);
        end

        // Test 5: overflow to r7 collapses to one beat with overflow data.
        set_req(2, 1'b1, 3'd7, 8'h11, 1'b1, 8'h22);
        #1 chk("t5.ready", 32'(req_ready_o), 32'b100);
        tick(); chk_wr("t5.beat", 1'b1, 3'd7, 8'h22, 2'd2);
        chk("t5.ovf",  32'(overFlag_o), 32'h0);
        chk("t5.busy", 32'(busy_o),     32'h0);
        req_valid_i = '0;
        tick(); chk_wr("t5.after", 1'b0, 3'd7, 8'h22, 2'd2);

        // Test 6: reset right after an accept (in OVER when split), ptr=0 beforehand.
        set_req(1, 1'b1, 3'd4, 8'h44, 1'b1, 8'h77);
        #1 chk("t6.ready", 32'(req_ready_o), 32'b010);
        tick(); chk_wr("t6.b1", 1'b1, 3'd4, 8'h44, 2'd1);
        chk("t6.busy", 32'(busy_o), 32'(SPLIT));
        req_valid_i = '0;
        #2 rst_n = 1'b0;
        #1;
        chk("t6.rst.ovf",  32'(overFlag_o), 32'h0);
        chk("t6.rst.busy", 32'(busy_o),     32'h0);
        chk_wr("t6.rst", 1'b0, 3'd0, 8'h00, 2'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick(); chk_wr("t6.rel1", 1'b0, 3'd0, 8'h00, 2'd0);
        tick(); chk_wr("t6.rel2", 1'b0, 3'd0, 8'h00, 2'd0);
        set_req(1, 1'b1, 3'd6, 8'h66, 1'b0, 8'h00);
        set_req(2, 1'b1, 3'd5, 8'h55, 1'b0, 8'h00);
        #1 chk("t6.ptr", 32'(req_ready_o), 32'b010);
        tick(); chk_wr("t6.acc", 1'b1, 3'd6, 8'h66, 2'd1);
        req_valid_i = '0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
